// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    CAPTURE,
    ACK
  } state_t;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DM    = 1'b1;

  function automatic logic is_masked(input logic port, input logic mask_valid,
                                     input logic mask_id);
    return mask_valid && (mask_id == port);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response and memory-side signals of the arbiter; master is the CPU
// side plus memory, slave is the arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = mem_arb_pkg::ADDR_W,
  parameter int DATA_W = mem_arb_pkg::DATA_W
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ack;
  logic [DATA_W-1:0] dm_rdata;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_writeData;
  logic              mem_trigWrite;
  logic              mem_trigRead;
  logic [DATA_W-1:0] mem_readData;

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_readData,
    input  if_ack, if_rdata, dm_ack, dm_rdata,
           mem_address, mem_writeData, mem_trigWrite, mem_trigRead
  );

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_readData,
    output if_ack, if_rdata, dm_ack, dm_rdata,
           mem_address, mem_writeData, mem_trigWrite, mem_trigRead
  );

endinterface

// File: rtl/mem_arb_grant.sv
// Combinational grant selection: dm wins a tie unless it was served last;
// the port acked in the previous cycle is excluded.
module mem_arb_grant (
  input  logic if_req,
  input  logic dm_req,
  input  logic mask_valid,
  input  logic mask_id,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);
  import mem_arb_pkg::*;

  logic if_live;
  logic dm_live;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    grant_valid = 1'b0;
    grant_id    = PORT_FETCH;
    if_live     = if_req && !is_masked(PORT_FETCH, mask_valid, mask_id);
    dm_live     = dm_req && !is_masked(PORT_DM, mask_valid, mask_id);

    if (if_live && dm_live) begin
      grant_valid = 1'b1;
      grant_id    = (last_grant == PORT_DM) ? PORT_FETCH : PORT_DM;
    end else if (dm_live) begin
      grant_valid = 1'b1;
      grant_id    = PORT_DM;
    end else if (if_live) begin
      grant_valid = 1'b1;
      grant_id    = PORT_FETCH;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one data memory between fetch and load/store ports, sequencing
// setup, a single-cycle read/write strobe, capture and a one-cycle ack.
module mem_port_arbiter #(
  parameter int ADDR_W = mem_arb_pkg::ADDR_W,
  parameter int DATA_W = mem_arb_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus,
  output logic              busy
);
  import mem_arb_pkg::*;

  state_t state;
  logic   grant_id;
  logic   we_q;
  logic   last_grant;
  logic   mask_valid;
  logic   mask_id;
  logic   grant_valid;
  logic   grant_next;

  mem_arb_grant u_grant (
    .if_req      (bus.if_req),
    .dm_req      (bus.dm_req),
    .mask_valid  (mask_valid),
    .mask_id     (mask_id),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_next)
  );

  // mem_address / mem_writeData double as the latched request; they hold in IDLE.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      // NOTE: the rdata holding registers are outputs, so they are reset too.
      state             <= IDLE;
      grant_id          <= PORT_FETCH;
      we_q              <= 1'b0;
      last_grant        <= PORT_FETCH;
      mask_valid        <= 1'b0;
      mask_id           <= PORT_FETCH;
      busy              <= 1'b0;
      bus.if_ack        <= 1'b0;
      bus.if_rdata      <= '0;
      bus.dm_ack        <= 1'b0;
      bus.dm_rdata      <= '0;
      bus.mem_address   <= '0;
      bus.mem_writeData <= '0;
      bus.mem_trigWrite <= 1'b0;
      bus.mem_trigRead  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mask_valid <= 1'b0;
          if (grant_valid) begin
            state    <= SETUP;
            busy     <= 1'b1;
            grant_id <= grant_next;
            we_q     <= (grant_next == PORT_DM) && bus.dm_we;
            if (grant_next == PORT_DM) begin
              bus.mem_address   <= bus.dm_addr;
              bus.mem_writeData <= bus.dm_wdata;
            end else begin
              bus.mem_address   <= bus.if_addr;
            end
          end
        end
        SETUP: begin
          state             <= STROBE;
          bus.mem_trigWrite <= we_q;
          bus.mem_trigRead  <= !we_q;
        end
        STROBE: begin
          state             <= CAPTURE;
          bus.mem_trigWrite <= 1'b0;
          bus.mem_trigRead  <= 1'b0;
        end
        CAPTURE: begin
          state <= ACK;
          if (grant_id == PORT_DM) begin
            bus.dm_ack <= 1'b1;
            if (!we_q) bus.dm_rdata <= bus.mem_readData;
          end else begin
            bus.if_ack   <= 1'b1;
            bus.if_rdata <= bus.mem_readData;
          end
        end
        ACK: begin
          state      <= IDLE;
          busy       <= 1'b0;
          bus.if_ack <= 1'b0;
          bus.dm_ack <= 1'b0;
          last_grant <= grant_id;
          mask_valid <= 1'b1;
          mask_id    <= grant_id;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // The memory sees mutually exclusive, single-cycle strobes.
  a_strobe_excl : assert property (@(posedge clk) disable iff (reset)
    !(bus.mem_trigRead && bus.mem_trigWrite));
  a_read_pulse : assert property (@(posedge clk) disable iff (reset)
    bus.mem_trigRead |=> !bus.mem_trigRead);
  a_write_pulse : assert property (@(posedge clk) disable iff (reset)
    bus.mem_trigWrite |=> !bus.mem_trigWrite);

endmodule
